// File: rtl/ram_port_arbiter_pkg.sv
// rtl/ram_port_arbiter_pkg.sv - shared types and constants for the RAM port arbiter
package ram_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_LD  = 1'b1
    } owner_e;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

endpackage

// File: rtl/ram_port_arbiter_rr_arb2.sv
// rtl/ram_port_arbiter_rr_arb2.sv - two-way round-robin picker; LD_PRIORITY_EN makes the loader win ties
module rr_arb2
    import ram_port_arbiter_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   cpu_req_i,
    input  logic   ld_req_i,
    input  logic   update_i,
    output logic   any_o,
    output owner_e win_o
);

    // Port that wins the next tie; starts at the CPU.
    owner_e ptr_q;

    assign any_o = cpu_req_i | ld_req_i;

    // Choose the winner from the current requests.
    always_comb begin
        win_o = OWN_CPU;
`ifdef LD_PRIORITY_EN
        if (ld_req_i) begin
            win_o = OWN_LD;
        end
`else
        if (cpu_req_i && ld_req_i) begin
            win_o = ptr_q;
        end else if (ld_req_i) begin
            win_o = OWN_LD;
        end
`endif
    end

    // After each grant the other port is favoured on the next tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= OWN_CPU;
        end else if (update_i) begin
            ptr_q <= (win_o == OWN_CPU) ? OWN_LD : OWN_CPU;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - shares one single-port RAM between CPU fetch and host loader; option LD_PRIORITY_EN
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int AW     = 16,
    parameter int DW     = 16,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic [AW-1:0] cpu_addr,
    output logic          cpu_gnt,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_valid,
    input  logic          ld_req,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    output logic          ld_gnt,
    output logic [DW-1:0] ld_rdata,
    output logic          ld_valid,
    output logic          ram_cs,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    localparam int CW = $clog2(RD_LAT) + 1;
    // WAIT holds for RD_LAT-1 cycles: load RD_LAT-2 and leave when the count hits zero.
    localparam logic [CW-1:0] WAIT_INIT = CW'((RD_LAT > 1) ? (RD_LAT - 2) : 0);

    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_rd_lat_range
        $error("ram_port_arbiter: RD_LAT must be within 1..4");
    end

    state_e          state_q;
    owner_e          owner_q;
    logic [CW-1:0]   cnt_q;
    logic            cpu_gnt_q;
    logic            cpu_valid_q;
    logic [DW-1:0]   cpu_rdata_q;
    logic            ld_gnt_q;
    logic            ld_valid_q;
    logic [DW-1:0]   ld_rdata_q;
    logic            ram_cs_q;
    logic            ram_we_q;
    logic [AW-1:0]   ram_addr_q;
    logic [DW-1:0]   ram_wdata_q;

    logic            arb_any;
    owner_e          arb_win;
    logic            arb_update;

    // Requests only matter in IDLE, so the pointer moves only on a real grant.
    assign arb_update = (state_q == ST_IDLE) && arb_any;

    rr_arb2 u_rr_arb2 (
        .clk       (clk),
        .rst       (rst),
        .cpu_req_i (cpu_req),
        .ld_req_i  (ld_req),
        .update_i  (arb_update),
        .any_o     (arb_any),
        .win_o     (arb_win)
    );

    // Access sequencer: arbitrate, issue one RAM access, wait out the latency, return data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_CPU;
            cnt_q       <= '0;
            cpu_gnt_q   <= 1'b0;
            cpu_valid_q <= 1'b0;
            cpu_rdata_q <= '0;
            ld_gnt_q    <= 1'b0;
            ld_valid_q  <= 1'b0;
            ld_rdata_q  <= '0;
            ram_cs_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else begin
            cpu_gnt_q   <= 1'b0;
            ld_gnt_q    <= 1'b0;
            ram_cs_q    <= 1'b0;
            cpu_valid_q <= 1'b0;
            ld_valid_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (arb_any) begin
                        state_q  <= ST_ISSUE;
                        owner_q  <= arb_win;
                        ram_cs_q <= 1'b1;
                        if (arb_win == OWN_LD) begin
                            ld_gnt_q    <= 1'b1;
                            ram_we_q    <= ld_we;
                            ram_addr_q  <= ld_addr;
                            ram_wdata_q <= ld_wdata;
                        end else begin
                            // The fetch port is read-only; ram_wdata keeps its last value.
                            cpu_gnt_q  <= 1'b1;
                            ram_we_q   <= 1'b0;
                            ram_addr_q <= cpu_addr;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (ram_we_q || RD_LAT == 1) begin
                        state_q <= ST_DONE;
                    end else begin
                        state_q <= ST_WAIT;
                        cnt_q   <= WAIT_INIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    if (owner_q == OWN_LD) begin
                        ld_valid_q <= 1'b1;
                        if (!ram_we_q) begin
                            ld_rdata_q <= ram_rdata;
                        end
                    end else begin
                        cpu_valid_q <= 1'b1;
                        cpu_rdata_q <= ram_rdata;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cpu_gnt   = cpu_gnt_q;
    assign cpu_valid = cpu_valid_q;
    assign cpu_rdata = cpu_rdata_q;
    assign ld_gnt    = ld_gnt_q;
    assign ld_valid  = ld_valid_q;
    assign ld_rdata  = ld_rdata_q;
    assign ram_cs    = ram_cs_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - directed scoreboard bench for ram_port_arbiter at RD_LAT 1 and 3
module tb_ram_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic        rst1, c1_req, l1_req, l1_we;
    logic [15:0] c1_addr, l1_addr, l1_wdata;
    logic        c1_gnt, c1_valid, l1_gnt, l1_valid, r1_cs, r1_we;
    logic [15:0] c1_rdata, l1_rdata, r1_addr, r1_wdata, r1_rdata;

    logic        rst3, c3_req, l3_req, l3_we;
    logic [15:0] c3_addr, l3_addr, l3_wdata;
    logic        c3_gnt, c3_valid, l3_gnt, l3_valid, r3_cs, r3_we;
    logic [15:0] c3_rdata, l3_rdata, r3_addr, r3_wdata, r3_rdata;

    ram_port_arbiter #(.AW(16), .DW(16), .RD_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst1),
        .cpu_req(c1_req), .cpu_addr(c1_addr), .cpu_gnt(c1_gnt), .cpu_rdata(c1_rdata), .cpu_valid(c1_valid),
        .ld_req(l1_req), .ld_we(l1_we), .ld_addr(l1_addr), .ld_wdata(l1_wdata),
        .ld_gnt(l1_gnt), .ld_rdata(l1_rdata), .ld_valid(l1_valid),
        .ram_cs(r1_cs), .ram_we(r1_we), .ram_addr(r1_addr), .ram_wdata(r1_wdata), .ram_rdata(r1_rdata)
    );

    ram_port_arbiter #(.AW(16), .DW(16), .RD_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst3),
        .cpu_req(c3_req), .cpu_addr(c3_addr), .cpu_gnt(c3_gnt), .cpu_rdata(c3_rdata), .cpu_valid(c3_valid),
        .ld_req(l3_req), .ld_we(l3_we), .ld_addr(l3_addr), .ld_wdata(l3_wdata),
        .ld_gnt(l3_gnt), .ld_rdata(l3_rdata), .ld_valid(l3_valid),
        .ram_cs(r3_cs), .ram_we(r3_we), .ram_addr(r3_addr), .ram_wdata(r3_wdata), .ram_rdata(r3_rdata)
    );

    // RAM models: data appears RD_LAT cycles after ram_cs, garbage otherwise
    logic [15:0] mem1 [0:255];
    logic [15:0] mem3 [0:255];
    logic [15:0] p1;
    logic [15:0] p3 [0:2];

    always @(posedge clk) begin
        if (r1_cs && r1_we) mem1[r1_addr[7:0]] <= r1_wdata;
        p1 <= r1_cs ? mem1[r1_addr[7:0]] : 16'hDEAD;
        if (r3_cs && r3_we) mem3[r3_addr[7:0]] <= r3_wdata;
        p3[0] <= r3_cs ? mem3[r3_addr[7:0]] : 16'hDEAD;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign r1_rdata = p1;
    assign r3_rdata = p3[2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: bit 16 marks a loader write (no read data to compare)
    logic [16:0] q1c[$], q1l[$], q3c[$], q3l[$];
    logic [16:0] e1c, e1l, e3c, e3l;

    always @(negedge clk) begin
        if (c1_valid) begin
            if (q1c.size() == 0) chk("c1_stray_valid", 1, 0);
            else begin e1c = q1c.pop_front(); chk("c1_rdata", c1_rdata, e1c[15:0]); end
        end
        if (l1_valid) begin
            if (q1l.size() == 0) chk("l1_stray_valid", 1, 0);
            else begin e1l = q1l.pop_front(); if (!e1l[16]) chk("l1_rdata", l1_rdata, e1l[15:0]); end
        end
        if (c3_valid) begin
            if (q3c.size() == 0) chk("c3_stray_valid", 1, 0);
            else begin e3c = q3c.pop_front(); chk("c3_rdata", c3_rdata, e3c[15:0]); end
        end
        if (l3_valid) begin
            if (q3l.size() == 0) chk("l3_stray_valid", 1, 0);
            else begin e3l = q3l.pop_front(); chk("l3_rdata", l3_rdata, e3l[15:0]); end
        end
    end

    // One access on the RD_LAT=1 instance with gnt, RAM-side and latency checks
    task automatic acc1(input bit ld, input bit we, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic [15:0] exp, input string tag);
        int  n;
        bit  cs_seen;
        if (ld) begin
            l1_req = 1'b1; l1_we = we; l1_addr = addr; l1_wdata = wdata;
            q1l.push_back({we, exp});
        end else begin
            c1_req = 1'b1; c1_addr = addr;
            q1c.push_back({1'b0, exp});
        end
        n = 0;
        while (!(ld ? l1_gnt : c1_gnt) && n < 20) begin @(negedge clk); n++; end
        chk({tag, "_gnt"}, ld ? l1_gnt : c1_gnt, 1);
        chk({tag, "_other_gnt"}, ld ? c1_gnt : l1_gnt, 0);
        chk({tag, "_ram"}, {r1_cs, r1_we, r1_addr}, {1'b1, we, addr});
        if (we) chk({tag, "_wdata"}, r1_wdata, wdata);
        c1_req = 1'b0; l1_req = 1'b0;
        n = 0; cs_seen = 1'b0;
        do begin
            @(negedge clk); n++;
            cs_seen = cs_seen | r1_cs;
        end while (!(ld ? l1_valid : c1_valid) && n < 20);
        chk({tag, "_lat"}, n, 2);
        chk({tag, "_cs_once"}, cs_seen, 0);
        @(negedge clk);
        chk({tag, "_valid_pulse"}, {c1_valid, l1_valid}, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  seen;
        bit  exp_ld;
        rst1 = 1'b0; rst3 = 1'b0;
        c1_req = 0; l1_req = 0; l1_we = 0; c1_addr = 0; l1_addr = 0; l1_wdata = 0;
        c3_req = 0; l3_req = 0; l3_we = 0; c3_addr = 0; l3_addr = 0; l3_wdata = 0;
        for (int i = 0; i < 256; i++) begin mem1[i] = 16'h0; mem3[i] = 16'h0; end
        mem1[8'h10] = 16'hA5A5;
        mem3[8'h20] = 16'hBEEF;
        mem3[8'h21] = 16'h1357;
        repeat (2) @(negedge clk);
        chk("rst_ctl",  {c1_gnt, c1_valid, l1_gnt, l1_valid, r1_cs, r1_we}, 0);
        chk("rst_data", {c1_rdata, l1_rdata, r1_addr, r1_wdata}, 0);
        rst1 = 1'b1; rst3 = 1'b1;
        @(negedge clk);

        // CPU-only read, loader write then CPU read-back, loader read
        acc1(0, 0, 16'h0010, 16'h0,    16'hA5A5, "t1_cpu_rd");
        chk("t1_rdata_hold", c1_rdata, 16'hA5A5);
        acc1(1, 1, 16'h0003, 16'h1234, 16'h0,    "t2_ld_wr");
        acc1(0, 0, 16'h0003, 16'h0,    16'h1234, "t2_cpu_rd");
        acc1(1, 0, 16'h0010, 16'h0,    16'hA5A5, "t2_ld_rd");
        chk("t2_cpu_rdata_hold", c1_rdata, 16'h1234);

        // Loader request raised and dropped while the CPU access is in flight
        c1_addr = 16'h0010; c1_req = 1'b1; q1c.push_back({1'b0, 16'hA5A5});
        n = 0;
        while (!c1_gnt && n < 20) begin @(negedge clk); n++; end
        chk("t3_cpu_gnt", c1_gnt, 1);
        c1_req = 1'b0;
        l1_req = 1'b1; l1_we = 1'b0; l1_addr = 16'h0003;
        @(negedge clk);
        l1_req = 1'b0;
        seen = 1'b0;
        repeat (8) begin @(negedge clk); seen = seen | l1_gnt; end
        chk("t3_dropped_req_no_gnt", seen, 0);
        acc1(1, 0, 16'h0003, 16'h0, 16'h1234, "t3_ld_rd");

        // Both requesting continuously
        c1_addr = 16'h0010; l1_addr = 16'h0003; l1_we = 1'b0;
        c1_req = 1'b1; l1_req = 1'b1;
        for (int g = 0; g < 4; g++) begin
            n = 0;
            do begin @(negedge clk); n++; end while (!(c1_gnt || l1_gnt) && n < 20);
            chk("t4_single_gnt", {c1_gnt, l1_gnt} == 2'b11, 0);
`ifdef LD_PRIORITY_EN
            exp_ld = 1'b1;
`else
            exp_ld = (g % 2) == 1;
`endif
            chk($sformatf("t4_winner%0d", g), l1_gnt, exp_ld);
            if (g > 0) chk($sformatf("t4_spacing%0d", g), n, 3);
            if (l1_gnt) q1l.push_back({1'b0, 16'h1234});
            else        q1c.push_back({1'b0, 16'hA5A5});
        end
        c1_req = 1'b0; l1_req = 1'b0;
        repeat (6) @(negedge clk);
        chk("t4_drained", q1c.size() + q1l.size(), 0);

        // RD_LAT=3: valid 4 cycles after gnt, next ram_cs only after valid
        c3_addr = 16'h0020; c3_req = 1'b1; q3c.push_back({1'b0, 16'hBEEF});
        n = 0;
        while (!c3_gnt && n < 20) begin @(negedge clk); n++; end
        chk("t5_gnt", {c3_gnt, r3_cs, r3_we, r3_addr}, {1'b1, 1'b1, 1'b0, 16'h0020});
        c3_req = 1'b0;
        l3_req = 1'b1; l3_we = 1'b0; l3_addr = 16'h0021;
        n = 0; seen = 1'b0;
        do begin @(negedge clk); n++; seen = seen | r3_cs; end while (!c3_valid && n < 20);
        chk("t5_lat4", n, 4);
        chk("t5_no_cs_before_valid", seen, 0);
        n = 0;
        while (!l3_gnt && n < 20) begin @(negedge clk); n++; end
        chk("t5_next_gnt_after_valid", n, 1);
        q3l.push_back({1'b0, 16'h1357});
        l3_req = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!l3_valid && n < 20);
        chk("t5_ld_lat4", n, 4);

        // Reset during WAIT: abandoned access, outputs cleared, CPU favoured afterwards
        @(negedge clk);
        c3_addr = 16'h0020; c3_req = 1'b1;
        n = 0;
        while (!c3_gnt && n < 20) begin @(negedge clk); n++; end
        chk("t6_gnt", c3_gnt, 1);
        c3_req = 1'b0;
        @(negedge clk);
        rst3 = 1'b0;
        #1;
        chk("t6_rst_ctl",  {c3_gnt, c3_valid, l3_gnt, l3_valid, r3_cs, r3_we}, 0);
        chk("t6_rst_data", {c3_rdata, l3_rdata, r3_addr, r3_wdata}, 0);
        repeat (2) @(negedge clk);
        rst3 = 1'b1;
        c3_req = 1'b1; l3_req = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!(c3_gnt || l3_gnt) && n < 20);
`ifdef LD_PRIORITY_EN
        chk("t6_first_winner_ld", {c3_gnt, l3_gnt}, 2'b01);
`else
        chk("t6_first_winner_cpu", {c3_gnt, l3_gnt}, 2'b10);
`endif
        if (l3_gnt) q3l.push_back({1'b0, 16'h1357});
        else        q3c.push_back({1'b0, 16'hBEEF});
        c3_req = 1'b0; l3_req = 1'b0;
        repeat (8) @(negedge clk);
        chk("t6_drained", q3c.size() + q3l.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
